// File: rtl/upcntr_pkg.sv
// rtl/upcntr_pkg.sv - shared constants for the up-counter sequencer family
package upcntr_pkg;

    localparam int DEFAULT_WIDTH = 2;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

endpackage

// File: rtl/upcntr_en.sv
// rtl/upcntr_en.sv - WIDTH-bit counter register with increment enable and sync clear
module upcntr_en #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // clear wins over increment; otherwise hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + ONE;
        end
    end

    // counter register, async active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/upcntr_seq.sv
// rtl/upcntr_seq.sv - start/pause/stop/auto-reload sequencer for an up-counter
module upcntr_seq
    import upcntr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             auto_reload_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       state_o
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             reload_q, reload_d;
    logic             done_q, done_d;

    logic             cnt_en;
    logic             cnt_clr;
    logic             advance;
    logic             at_term;

    assign at_term = (count_o == term_q);

    // next-state: clear beats stop beats start; a resume from PAUSE advances
    // immediately so that pausing never costs a counting cycle
    always_comb begin
        state_d  = state_q;
        term_d   = term_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        advance  = 1'b0;

        if (clear_i) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        term_d   = term_i;
                        reload_d = auto_reload_i;
                        cnt_clr  = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!stop_i && start_i) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (advance) begin
            state_d = ST_RUN;
            if (!at_term) begin
                cnt_en = 1'b1;
            end else begin
                done_d = 1'b1;
                if (reload_q) begin
                    cnt_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // control registers, async active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            term_q   <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            term_q   <= term_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    upcntr_en #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .count_o (count_o)
    );

    assign busy_o  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule
